// File: rtl/elevator_scheduler.sv
// elevator_scheduler: request queue and car sequencer for a four-level elevator.
// Holds up to four pending levels, moves the car one level per LVL_TRAVEL_CYCLES
// cycles, serves any queued level it passes through, and holds the door open
// for DOOR_CYCLES cycles at each stop.
// Optional feature macro: ELEV_DOOR_REOPEN_EN -- a press of the current level
// while the door is open restarts the door timer.
module elevator_scheduler #(
    parameter int LVL_TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pressed_en,
    input  logic [1:0] pressed_lvl,
    output logic [1:0] pos_lvl,
    output logic [7:0] queue,
    output logic [2:0] tail,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open,
    output logic       req_dropped
);

    typedef enum logic [1:0] {IDLE, MOVE, CHECK, DOOR} state_t;

    localparam logic [15:0] TRAVEL_LAST = 16'(LVL_TRAVEL_CYCLES - 1);
    localparam logic [15:0] DOOR_LAST   = 16'(DOOR_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [1:0]  pos_reg, pos_next;
    logic [1:0]  slot_reg [4];
    logic [1:0]  slot_next [4];
    logic [1:0]  add_slot [4];
    logic [1:0]  rem_slot [4];
    logic [2:0]  tail_reg, tail_next, add_tail;
    logic [15:0] cnt_reg, cnt_next;
    logic        up_reg, up_next;
    logic        moving_up_reg, moving_down_reg, door_open_reg, req_dropped_reg;

    logic [3:0]  hit;
    logic [3:0]  match;
    logic        present, self_idle, self_door, rejectable, add_ok, drop;
    logic        any_match, reopen;
    logic [1:0]  match_idx;

    // Press classification: duplicates and presses of the current level while
    // stopped never enter the queue; everything else is added or dropped.
    assign present    = |hit;
    assign self_idle  = (state_reg == IDLE) && (pressed_lvl == pos_reg);
    assign self_door  = (state_reg == DOOR) && (pressed_lvl == pos_reg);
    assign rejectable = pressed_en && !present && !self_idle && !self_door;
    assign add_ok     = rejectable && (tail_reg != 3'd4);
    assign drop       = rejectable && (tail_reg == 3'd4);
    assign add_tail   = tail_reg + {2'b00, add_ok};

`ifdef ELEV_DOOR_REOPEN_EN
    assign reopen = pressed_en && self_door;
`else
    assign reopen = 1'b0;
`endif

    // Per-slot duplicate detection, post-add queue, and removal match.
    // Slots at or above tail are always 0, so shifting them down zero-fills.
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        assign hit[gi]      = (3'(gi) < tail_reg) && (slot_reg[gi] == pressed_lvl);
        assign add_slot[gi] = (add_ok && (tail_reg == 3'(gi))) ? pressed_lvl : slot_reg[gi];
        assign match[gi]    = (3'(gi) < add_tail) && (add_slot[gi] == pos_reg);
        if (gi < 3) begin : g_shift
            assign rem_slot[gi] = (3'(gi) < {1'b0, match_idx}) ? add_slot[gi] : add_slot[gi+1];
        end else begin : g_top
            assign rem_slot[gi] = 2'b00;
        end
    end

    // Locate the slot holding the current level (levels are unique in the queue).
    always_comb begin
        any_match = 1'b0;
        match_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (match[i]) begin
                any_match = 1'b1;
                match_idx = 2'(i);
            end
        end
    end

    // Next-state, position, counter and queue update.
    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        cnt_next   = cnt_reg;
        up_next    = up_reg;
        tail_next  = add_tail;
        for (int i = 0; i < 4; i++) slot_next[i] = add_slot[i];
        case (state_reg)
            IDLE: begin
                if (pressed_en && self_idle) begin
                    state_next = DOOR;
                    cnt_next   = '0;
                end else if (tail_reg != 3'd0) begin
                    if (slot_reg[0] == pos_reg) begin
                        state_next = CHECK;
                    end else begin
                        state_next = MOVE;
                        up_next    = slot_reg[0] > pos_reg;
                        cnt_next   = '0;
                    end
                end
            end
            MOVE: begin
                if (cnt_reg == TRAVEL_LAST) begin
                    cnt_next   = '0;
                    state_next = CHECK;
                    if (up_reg && pos_reg != 2'd3)
                        pos_next = pos_reg + 2'd1;
                    else if (!up_reg && pos_reg != 2'd0)
                        pos_next = pos_reg - 2'd1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            CHECK: begin
                cnt_next = '0;
                if (any_match) begin
                    for (int i = 0; i < 4; i++) slot_next[i] = rem_slot[i];
                    tail_next  = add_tail - 3'd1;
                    state_next = DOOR;
                end else if (add_tail != 3'd0) begin
                    state_next = MOVE;
                    up_next    = add_slot[0] > pos_reg;
                end else begin
                    state_next = IDLE;
                end
            end
            DOOR: begin
                if (reopen) begin
                    cnt_next = '0;
                end else if (cnt_reg == DOOR_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State registers; outputs are registered from the next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            pos_reg         <= 2'd0;
            tail_reg        <= 3'd0;
            cnt_reg         <= '0;
            up_reg          <= 1'b0;
            moving_up_reg   <= 1'b0;
            moving_down_reg <= 1'b0;
            door_open_reg   <= 1'b0;
            req_dropped_reg <= 1'b0;
            for (int i = 0; i < 4; i++) slot_reg[i] <= 2'd0;
        end else begin
            state_reg       <= state_next;
            pos_reg         <= pos_next;
            tail_reg        <= tail_next;
            cnt_reg         <= cnt_next;
            up_reg          <= up_next;
            moving_up_reg   <= (state_next == MOVE) && up_next;
            moving_down_reg <= (state_next == MOVE) && !up_next;
            door_open_reg   <= (state_next == DOOR);
            req_dropped_reg <= drop;
            for (int i = 0; i < 4; i++) slot_reg[i] <= slot_next[i];
        end
    end

    assign pos_lvl     = pos_reg;
    assign queue       = {slot_reg[3], slot_reg[2], slot_reg[1], slot_reg[0]};
    assign tail        = tail_reg;
    assign moving_up   = moving_up_reg;
    assign moving_down = moving_down_reg;
    assign door_open   = door_open_reg;
    assign req_dropped = req_dropped_reg;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed scenarios plus randomized presses, with every
// cycle's outputs predicted by a queue-based reference model and checked by a
// separate monitor through a scoreboard FIFO.
module tb_elevator_scheduler;

    localparam int TRAVEL = 4;
    localparam int DOOR   = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pressed_en = 1'b0;
    logic [1:0] pressed_lvl = 2'd0;
    logic [1:0] pos_lvl;
    logic [7:0] queue;
    logic [2:0] tail;
    logic       moving_up, moving_down, door_open, req_dropped;

    elevator_scheduler #(.LVL_TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
        .clk(clk), .rst(rst), .pressed_en(pressed_en), .pressed_lvl(pressed_lvl),
        .pos_lvl(pos_lvl), .queue(queue), .tail(tail), .moving_up(moving_up),
        .moving_down(moving_down), .door_open(door_open), .req_dropped(req_dropped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Modes: 0 idle, 1 travelling, 2 arrival check, 3 door open.
    int  m_pos, m_mode, m_cnt;
    bit  m_up, m_drop;
    int  m_q[$];

    typedef struct {
        int pos; int q; int tl; int up; int dn; int door; int drop;
    } exp_t;
    exp_t sb[$];

    task automatic model_step(input bit r, input bit en, input int lvl);
        int  nq[$];
        bit  present, self_idle, self_door, reopen;
        int  idx;
        if (r) begin
            m_pos = 0; m_mode = 0; m_cnt = 0; m_up = 0; m_drop = 0;
            m_q.delete();
            return;
        end
        present = 0;
        foreach (m_q[i]) if (m_q[i] == lvl) present = 1;
        self_idle = (m_mode == 0) && (lvl == m_pos);
        self_door = (m_mode == 3) && (lvl == m_pos);
`ifdef ELEV_DOOR_REOPEN_EN
        reopen = en && self_door;
`else
        reopen = 0;
`endif
        nq = m_q;
        m_drop = 0;
        if (en && !present && !self_idle && !self_door) begin
            if (m_q.size() == 4) m_drop = 1;
            else nq.push_back(lvl);
        end
        case (m_mode)
            0: begin
                if (en && self_idle) begin
                    m_mode = 3; m_cnt = 0;
                end else if (m_q.size() > 0) begin
                    if (m_q[0] == m_pos) m_mode = 2;
                    else begin m_mode = 1; m_up = m_q[0] > m_pos; m_cnt = 0; end
                end
            end
            1: begin
                if (m_cnt == TRAVEL - 1) begin
                    m_pos = m_up ? m_pos + 1 : m_pos - 1;
                    if (m_pos > 3) m_pos = 3;
                    if (m_pos < 0) m_pos = 0;
                    m_mode = 2; m_cnt = 0;
                end else m_cnt++;
            end
            2: begin
                idx = -1;
                foreach (nq[i]) if (nq[i] == m_pos) idx = i;
                m_cnt = 0;
                if (idx >= 0) begin nq.delete(idx); m_mode = 3; end
                else if (nq.size() > 0) begin m_mode = 1; m_up = nq[0] > m_pos; end
                else m_mode = 0;
            end
            default: begin
                if (reopen) m_cnt = 0;
                else if (m_cnt == DOOR - 1) begin m_mode = 0; m_cnt = 0; end
                else m_cnt++;
            end
        endcase
        m_q = nq;
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.q = 0;
        foreach (m_q[i]) e.q += m_q[i] << (2 * i);
        e.pos  = m_pos;
        e.tl   = m_q.size();
        e.up   = (m_mode == 1 && m_up) ? 1 : 0;
        e.dn   = (m_mode == 1 && !m_up) ? 1 : 0;
        e.door = (m_mode == 3) ? 1 : 0;
        e.drop = m_drop ? 1 : 0;
        return e;
    endfunction

    // One clock of stimulus: drive at the falling edge, predict, wait one cycle.
    task automatic tick(input bit r, input bit en, input int lvl);
        rst = r;
        pressed_en = en;
        pressed_lvl = 2'(lvl);
        if (en && !r)
            $display("t=%0t press lvl=%0d pos=%0d tail=%0d", $time, lvl, pos_lvl, tail);
        model_step(r, en, lvl);
        sb.push_back(snap());
        @(negedge clk);
    endtask

    // Monitor: compare every registered output one time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_pos", int'(pos_lvl), e.pos);
                chk("sb_queue", int'(queue), e.q);
                chk("sb_tail", int'(tail), e.tl);
                chk("sb_up", int'(moving_up), e.up);
                chk("sb_down", int'(moving_down), e.dn);
                chk("sb_door", int'(door_open), e.door);
                chk("sb_drop", int'(req_dropped), e.drop);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int len;
        @(negedge clk);

        // Reset state.
        tick(1, 0, 0);
        chk("rst_pos", int'(pos_lvl), 0);
        chk("rst_tail", int'(tail), 0);
        chk("rst_queue", int'(queue), 0);
        chk("rst_outs", int'({moving_up, moving_down, door_open, req_dropped}), 0);

        // Single trip 0 -> 2 with exact cycle timing.
        tick(0, 1, 2);
        for (int k = 1; k <= 18; k++) begin
            chk($sformatf("trip_up_c%0d", k), int'(moving_up),
                ((k >= 2 && k <= 5) || (k >= 7 && k <= 10)) ? 1 : 0);
            chk($sformatf("trip_door_c%0d", k), int'(door_open), (k >= 12 && k <= 17) ? 1 : 0);
            if (k == 1)  chk("trip_tail_c1", int'(tail), 1);
            if (k == 6)  chk("trip_pos_c6", int'(pos_lvl), 1);
            if (k == 11) chk("trip_pos_c11", int'(pos_lvl), 2);
            if (k == 12) chk("trip_tail_c12", int'(tail), 0);
            tick(0, 0, 0);
        end

        // Intermediate stop: queue 3, then press 1 while travelling.
        tick(1, 0, 0);
        tick(0, 1, 3);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 1, 1);
        for (int k = 0; k < 60 && !door_open; k++) tick(0, 0, 0);
        chk("mid_door_reached", int'(door_open), 1);
        chk("mid_pos", int'(pos_lvl), 1);
        chk("mid_queue", int'(queue), 3);
        chk("mid_tail", int'(tail), 1);
        for (int k = 0; k < 60 && door_open; k++) tick(0, 0, 0);
        for (int k = 0; k < 60 && !door_open; k++) tick(0, 0, 0);
        chk("mid_final_pos", int'(pos_lvl), 3);
        chk("mid_final_door", int'(door_open), 1);
        chk("mid_final_tail", int'(tail), 0);

        // Fill the queue, then repeat presses: duplicates change nothing.
        tick(1, 0, 0);
        tick(0, 1, 1);
        tick(0, 1, 2);
        tick(0, 1, 3);
        tick(0, 1, 0);
        chk("full_tail", int'(tail), 4);
        chk("full_queue", int'(queue), 8'b00_11_10_01);
        tick(0, 1, 2);
        chk("dup_drop_a", int'(req_dropped), 0);
        tick(0, 1, 3);
        chk("dup_tail", int'(tail), 4);
        chk("dup_drop_b", int'(req_dropped), 0);

        // Press current level while idle: door opens next cycle, nothing queued.
        tick(1, 0, 0);
        tick(0, 1, 0);
        chk("self_door", int'(door_open), 1);
        chk("self_tail", int'(tail), 0);

        // Press current level on the third door cycle.
        tick(1, 0, 0);
        tick(0, 1, 0);
        len = 0;
        for (int k = 1; k <= 30; k++) begin
            if (door_open) len++;
            tick(0, (k == 3), 0);
        end
`ifdef ELEV_DOOR_REOPEN_EN
        chk("reopen_len", len, 9);
`else
        chk("reopen_len", len, 6);
`endif

        // Reset in the middle of a trip.
        tick(1, 0, 0);
        tick(0, 1, 3);
        tick(0, 1, 2);
        for (int k = 0; k < 6; k++) tick(0, 0, 0);
        chk("mrst_pre_pos", int'(pos_lvl), 1);
        chk("mrst_pre_tail", int'(tail), 2);
        chk("mrst_pre_up", int'(moving_up), 1);
        tick(1, 0, 0);
        chk("mrst_pos", int'(pos_lvl), 0);
        chk("mrst_tail", int'(tail), 0);
        chk("mrst_queue", int'(queue), 0);
        chk("mrst_outs", int'({moving_up, moving_down, door_open, req_dropped}), 0);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 2500; k++)
            tick(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 3)));
        tick(0, 0, 0);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
